// File: rtl/regfile_bypass_sb.sv
// Decode-stage register file: NUM_RD combinational read ports, one write port with
// write-to-read bypass, and a busy scoreboard that stalls reads of pending load results.
module regfile_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_use,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    output logic                       stall,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    input  logic                       flush,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic ZR_EN = (ZERO_REG != 32'sd0);

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              wr_act_s;
    logic              wr_zero_s;

    // The write port only counts outside reset; it also drives the bypass path.
    assign wr_act_s  = rst & wr_en;
    assign wr_zero_s = ZR_EN && (wr_addr == {ADDR_W{1'b0}});

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              hit_s;
        logic              zero_s;
        logic [DATA_W-1:0] data_s;

        assign addr_s = rd_addr[p*ADDR_W +: ADDR_W];
        assign zero_s = ZR_EN && (addr_s == {ADDR_W{1'b0}});
        assign hit_s  = wr_act_s && (wr_addr == addr_s) && !zero_s;

        // Per-port read mux: hardwired zero, then bypass, then stored value.
        always_comb begin
            if (zero_s) begin
                data_s = {DATA_W{1'b0}};
            end else if (hit_s) begin
                data_s = wr_data;
            end else begin
                data_s = regs_q[addr_s];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_s;
        // A write completing this cycle is bypassed, so it no longer counts as busy.
        assign rd_busy[p] = rst & busy_q[addr_s] & ~hit_s;
    end

    assign stall    = |(rd_use & rd_busy);
    assign busy_cnt = busy_cnt_q;

    // Scoreboard next state: flush beats issue, issue beats a same-cycle completing write.
    always_comb begin
        busy_d = {NREGS{1'b0}};
        for (int r = 0; r < NREGS; r++) begin
            if (ZR_EN && (r == 0)) begin
                busy_d[r] = 1'b0;
            end else if (flush) begin
                busy_d[r] = 1'b0;
            end else if (issue_en && (issue_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        busy_cnt_d = popcount(busy_d);
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {DATA_W{1'b0}};
            end
            busy_q     <= {NREGS{1'b0}};
            busy_cnt_q <= {(ADDR_W+1){1'b0}};
        end else begin
            if (wr_en && !wr_zero_s) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Randomised scoreboard bench for regfile_bypass_sb (NUM_RD=3, DATA_W=16): a driver
// pushes expected outputs from an array-based reference model, a monitor pops and compares.
module tb_regfile_bypass_sb;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int NREGS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR-1:0]     rd_use;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              stall;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic              flush;
    logic [AW:0]       busy_cnt;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
        .rd_busy(rd_busy), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .issue_en(issue_en), .issue_addr(issue_addr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic [NR-1:0][DW-1:0] data;
        logic [NR-1:0]         busy;
        logic                  stall;
        logic [AW:0]           cnt;
        int                    cyc;
    } exp_t;

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    logic [DW-1:0]   m_regs[NREGS];
    bit              m_busy[NREGS];

    function automatic logic [NR*AW-1:0] pk(input int a0, input int a1, input int a2);
        logic [AW-1:0] x0, x1, x2;
        x0 = AW'(a0);
        x1 = AW'(a1);
        x2 = AW'(a2);
        return {x2, x1, x0};
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then advance the model.
    task automatic drive(input bit chk, input bit r, input logic [NR*AW-1:0] ra,
                         input logic [NR-1:0] use_v, input bit we, input int wa,
                         input int wd, input bit ie, input int ia, input bit fl);
        exp_t          e;
        logic [AW-1:0] a;
        logic [AW-1:0] wa_v;
        logic [DW-1:0] wd_v;
        bit            hit;
        int            n;
        wa_v = AW'(wa);
        wd_v = DW'(wd);
        @(posedge clk);
        #1;
        rst = r; rd_addr = ra; rd_use = use_v; wr_en = we; wr_addr = wa_v;
        wr_data = wd_v; issue_en = ie; issue_addr = AW'(ia); flush = fl;
        e.stall = 1'b0;
        for (int p = 0; p < NR; p++) begin
            a   = ra[p*AW +: AW];
            hit = r && we && (wa_v == a) && (a != 0);
            if (a == 0)      e.data[p] = '0;
            else if (hit)    e.data[p] = wd_v;
            else             e.data[p] = m_regs[a];
            e.busy[p] = r && m_busy[a] && !hit;
            if (use_v[p] && e.busy[p]) e.stall = 1'b1;
        end
        n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        e.cnt = (AW+1)'(n);
        e.cyc = cyc;
        if (chk) sb_q.push_back(e);
        if (!r) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wa_v != 0) m_regs[wa_v] = wd_v;
            if (fl) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            end else begin
                if (we) m_busy[wa_v] = 1'b0;
                if (ie && AW'(ia) != 0) m_busy[AW'(ia)] = 1'b1;
            end
        end
        cyc++;
    endtask

    // Monitor: compare every presented cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int p = 0; p < NR; p++) begin
                check($sformatf("rd_data[%0d]", p), e.cyc, 32'(rd_data[p*DW +: DW]), 32'(e.data[p]));
            end
            check("rd_busy", e.cyc, 32'(rd_busy), 32'(e.busy));
            check("stall", e.cyc, 32'(stall), 32'(e.stall));
            check("busy_cnt", e.cyc, 32'(busy_cnt), 32'(e.cnt));
        end
    end

    initial begin
        rst = 1'b0; rd_addr = '0; rd_use = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        // Initial reset edge: outputs are undefined before it, so it is not checked.
        drive(1'b0, 1'b0, pk(0, 0, 0), 3'b000, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, pk(1, 2, 3), 3'b111, 1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Fill regs 1..31 (some also busy), then one reset edge clears everything.
        for (int i = 1; i < NREGS; i++) begin
            drive(1'b1, 1'b1, pk(i, i - 1, 0), 3'b011, 1'b1, i, i * 3 + 1, (i % 4) == 0, i, 1'b0);
        end
        drive(1'b1, 1'b0, pk(4, 8, 31), 3'b111, 1'b1, 4, 99, 1'b1, 9, 1'b0);
        drive(1'b1, 1'b1, pk(4, 8, 31), 3'b111, 1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Basic writes, reads and the hardwired zero register.
        drive(1'b1, 1'b1, pk(1, 2, 0), 3'b000, 1'b1, 1, 2015, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, pk(1, 2, 0), 3'b000, 1'b1, 2, 404, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, pk(1, 2, 0), 3'b000, 1'b1, 0, 7, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, pk(0, 1, 2), 3'b000, 1'b0, 0, 0, 1'b1, 0, 1'b0);

        // Same-cycle bypass on port 0 and port 2 naming the same register.
        drive(1'b1, 1'b1, pk(3, 1, 3), 3'b000, 1'b1, 3, 2419, 1'b0, 0, 1'b0);

        // Load scoreboard: stall while pending, released by the completing write.
        drive(1'b1, 1'b1, pk(3, 0, 0), 3'b001, 1'b0, 0, 0, 1'b1, 3, 1'b0);
        drive(1'b1, 1'b1, pk(3, 0, 0), 3'b001, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, pk(3, 3, 0), 3'b011, 1'b1, 3, 404, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, pk(3, 0, 0), 3'b001, 1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Collisions: issue beats write, flush beats issue, rd_use gates stall.
        drive(1'b1, 1'b1, pk(5, 0, 0), 3'b001, 1'b1, 5, 55, 1'b1, 5, 1'b0);
        drive(1'b1, 1'b1, pk(5, 6, 0), 3'b011, 1'b0, 0, 0, 1'b1, 8, 1'b0);
        drive(1'b1, 1'b1, pk(5, 8, 6), 3'b111, 1'b0, 0, 0, 1'b1, 6, 1'b1);
        drive(1'b1, 1'b1, pk(5, 8, 6), 3'b111, 1'b0, 0, 0, 1'b1, 7, 1'b0);
        drive(1'b1, 1'b1, pk(7, 7, 1), 3'b000, 1'b1, 9, 9, 1'b1, 7, 1'b0);
        drive(1'b1, 1'b1, pk(7, 9, 0), 3'b010, 1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Random sweep with occasional flush and mid-run reset.
        for (int k = 0; k < 10000; k++) begin
            int ra0, ra1, ra2, wa, ia;
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            ra0 = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            ra1 = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            ra2 = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            wa  = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            ia  = narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            drive(1'b1, $urandom_range(0, 299) != 0, pk(ra0, ra1, ra2),
                  3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, wa,
                  int'($urandom_range(0, 65535)), $urandom_range(0, 2) == 0, ia,
                  $urandom_range(0, 39) == 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", cyc, 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
